// File: rtl/div8by4_radix4_if.sv
// Operand/result handshake bundle for div8by4_radix4; master drives operands and out_ready.
interface div8by4_radix4_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] N;
  logic [3:0] D;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Q;
  logic [3:0] R;
  logic       dbz;
  logic       chk_err;

  modport master (
    output in_valid, N, D, out_ready,
    input  in_ready, out_valid, Q, R, dbz, chk_err
  );

  modport slave (
    input  in_valid, N, D, out_ready,
    output in_ready, out_valid, Q, R, dbz, chk_err
  );
endinterface

// File: rtl/div8by4_radix4.sv
// 8/4 unsigned radix-4 divider: 4 CALC cycles (result visible at the 5th edge after accept), 1 for D=0; holds result until out_ready.
// Optional DIV_SELFCHECK_EN: recompute Q*D+R on entry to DONE and flag mismatch on chk_err.
module div8by4_radix4 (
  input  logic           clk,
  input  logic           rst_n,
  div8by4_radix4_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     r_state, w_next;
  logic [7:0] r_n, r_q;
  logic [3:0] r_d, r_rem;
  logic [1:0] r_cnt;
  logic       r_dbz;

  logic       w_accept, w_consume, w_last;
  logic [1:0] w_pair, w_digit;
  logic [5:0] w_pr, w_d1, w_d2, w_d3;
  logic [3:0] w_kd;
  logic [3:0] w_rem_nxt;
  logic [7:0] w_q_nxt;

  assign w_accept  = (r_state == IDLE) && bus.in_valid;
  assign w_consume = (r_state == DONE) && bus.out_ready;
  assign w_last    = (r_state == CALC) && (r_cnt == 2'd3);

  always_comb begin
    w_pair = 2'd0;
    case (r_cnt)
      2'd0: w_pair = r_n[7:6];
      2'd1: w_pair = r_n[5:4];
      2'd2: w_pair = r_n[3:2];
      2'd3: w_pair = r_n[1:0];
      default: w_pair = 2'd0;
    endcase
  end

  // Digit select by comparing the partial remainder against D, 2D and 3D.
  assign w_pr = {r_rem, w_pair};
  assign w_d1 = {2'b00, r_d};
  assign w_d2 = {1'b0, r_d, 1'b0};
  assign w_d3 = w_d1 + w_d2;

  always_comb begin
    w_digit = 2'd0;
    w_kd    = 4'd0;
    if (w_pr >= w_d3) begin
      w_digit = 2'd3;
      w_kd    = r_d + {r_d[2:0], 1'b0};
    end else if (w_pr >= w_d2) begin
      w_digit = 2'd2;
      w_kd    = {r_d[2:0], 1'b0};
    end else if (w_pr >= w_d1) begin
      w_digit = 2'd1;
      w_kd    = r_d;
    end
  end

  // True remainder is < D <= 15, so modulo-16 arithmetic on the low nibble is exact.
  assign w_rem_nxt = w_pr[3:0] - w_kd;
  assign w_q_nxt   = {r_q[5:0], w_digit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_next = (bus.D == 4'd0) ? DONE : CALC;
      CALC:    if (r_cnt == 2'd3) w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n   <= 8'd0;
      r_d   <= 4'd0;
      r_q   <= 8'd0;
      r_rem <= 4'd0;
      r_cnt <= 2'd0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_n   <= bus.N;
      r_d   <= bus.D;
      r_cnt <= 2'd0;
      r_dbz <= (bus.D == 4'd0);
      r_q   <= (bus.D == 4'd0) ? 8'hFF : 8'd0;
      r_rem <= (bus.D == 4'd0) ? bus.N[3:0] : 4'd0;
    end else if (r_state == CALC) begin
      r_q   <= w_q_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt + 2'd1;
    end
  end

`ifdef DIV_SELFCHECK_EN
  logic        r_chk;
  logic [11:0] w_prod;

  assign w_prod = 12'(w_q_nxt) * 12'(r_d) + 12'(w_rem_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_chk <= 1'b0;
    else if (w_accept || w_consume)  r_chk <= 1'b0;
    else if (w_last)                 r_chk <= (w_prod != {4'd0, r_n});
  end

  assign bus.chk_err = r_chk;
`else
  assign bus.chk_err = 1'b0;
`endif

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.Q         = r_q;
  assign bus.R         = r_rem;
  assign bus.dbz       = r_dbz;
endmodule

// File: tb/tb_div8by4_radix4.sv
// Directed and exhaustive checks of div8by4_radix4 against hand-computed values and a divide/modulo model.
module tb_div8by4_radix4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  div8by4_radix4_if bus ();

  div8by4_radix4 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full transaction; out_ready is held low for 'stall' cycles once the result appears.
  task automatic run_op(input logic [7:0] n, input logic [3:0] d, input int stall, input bit poke,
                        input bit rdy_early, output logic [7:0] q, output logic [3:0] r,
                        output logic z, output logic ce, output int lat);
    int guard;
    @(negedge clk);
    bus.N = n;
    bus.D = d;
    bus.in_valid = 1'b1;
    bus.out_ready = rdy_early;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", 16'(bus.in_ready), 16'd1);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.N = ~n;
      bus.D = ~d;
      lat++;
    end while (!bus.out_valid && lat < 20);
    q  = bus.Q;
    r  = bus.R;
    z  = bus.dbz;
    ce = bus.chk_err;
    bus.out_ready = (stall == 0);
    for (int i = 0; i < stall; i++) begin
      if (poke) bus.in_valid = ~bus.in_valid;
      @(negedge clk);
      check("stall_q", 16'(bus.Q), 16'(q));
      check("stall_r", 16'(bus.R), 16'(r));
      check("stall_valid", 16'(bus.out_valid), 16'd1);
      check("stall_in_ready", 16'(bus.in_ready), 16'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("consume_in_ready", 16'(bus.in_ready), 16'd1);
    check("consume_out_valid", 16'(bus.out_valid), 16'd0);
  endtask

  typedef struct {
    logic [7:0] n;
    logic [3:0] d;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         stall;
    bit         poke;
    bit         rdy;
  } vec_t;

  vec_t vecs[9] = '{
    '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 0, 1'b0, 1'b1},
    '{8'hAB,  4'd0,  8'hFF,  4'hB,  1'b1, 0, 1'b0, 1'b0},
    '{8'd9,   4'd3,  8'd3,   4'd0,  1'b0, 6, 1'b1, 1'b0},
    '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0, 1, 1'b0, 1'b0},
    '{8'd156, 4'd1,  8'd156, 4'd0,  1'b0, 0, 1'b0, 1'b1},
    '{8'd3,   4'd9,  8'd0,   4'd3,  1'b0, 2, 1'b0, 1'b0},
    '{8'hFF,  4'hF,  8'd17,  4'd0,  1'b0, 0, 1'b0, 1'b0},
    '{8'd250, 4'd9,  8'd27,  4'd7,  1'b0, 1, 1'b0, 1'b1},
    '{8'd0,   4'd0,  8'hFF,  4'd0,  1'b1, 0, 1'b0, 1'b0}
  };

  initial begin
    logic [7:0] q;
    logic [3:0] r;
    logic       z, ce;
    int         lat;
    bit         seen;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.N = 8'd0;
    bus.D = 4'd0;

    #12;
    check("rst_in_ready", 16'(bus.in_ready), 16'd1);
    check("rst_out_valid", 16'(bus.out_valid), 16'd0);
    check("rst_q", 16'(bus.Q), 16'd0);
    check("rst_r", 16'(bus.R), 16'd0);
    check("rst_dbz", 16'(bus.dbz), 16'd0);
    check("rst_chk", 16'(bus.chk_err), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].n, vecs[i].d, vecs[i].stall, vecs[i].poke, vecs[i].rdy, q, r, z, ce, lat);
      check("dir_q", 16'(q), 16'(vecs[i].q));
      check("dir_r", 16'(r), 16'(vecs[i].r));
      check("dir_dbz", 16'(z), 16'(vecs[i].z));
      check("dir_chk", 16'(ce), 16'd0);
      check("dir_latency", 16'(lat), (vecs[i].d == 4'd0) ? 16'd1 : 16'd5);
    end

    // Reset in the 2nd CALC cycle discards the operation.
    @(negedge clk);
    bus.N = 8'd255;
    bus.D = 4'd15;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 16'(bus.in_ready), 16'd1);
    check("mid_rst_out_valid", 16'(bus.out_valid), 16'd0);
    check("mid_rst_q", 16'(bus.Q), 16'd0);
    check("mid_rst_r", 16'(bus.R), 16'd0);
    check("mid_rst_dbz", 16'(bus.dbz), 16'd0);
    check("mid_rst_chk", 16'(bus.chk_err), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("post_rst_no_valid", 16'(seen), 16'd0);
    run_op(8'd5, 4'd2, 0, 1'b0, 1'b0, q, r, z, ce, lat);
    check("post_rst_q", 16'(q), 16'd2);
    check("post_rst_r", 16'(r), 16'd1);
    check("post_rst_latency", 16'(lat), 16'd5);

    // Exhaustive sweep with random backpressure against a divide/modulo model.
    for (int n = 0; n < 256; n++) begin
      for (int d = 0; d < 16; d++) begin
        logic [12:0] exp_v;
        exp_v = (d == 0) ? {1'b1, 8'hFF, 4'(n)} : {1'b0, 8'(n / d), 4'(n % d)};
        run_op(8'(n), 4'(d), int'($urandom_range(0, 2)), 1'b0, 1'($urandom_range(0, 1)),
               q, r, z, ce, lat);
        check($sformatf("sweep_%0d_%0d", n, d), 16'({z, q, r}), 16'(exp_v));
        check("sweep_chk", 16'(ce), 16'd0);
        check("sweep_latency", 16'(lat), (d == 0) ? 16'd1 : 16'd5);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
